// File: rtl/md_filter_pkg.sv
// Shared constants and payload type for the filter drain path.
package md_filter_pkg;

  localparam int unsigned NUM_FILTER      = 4;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned FILTER_ID_WIDTH = 2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]      data;
    logic [FILTER_ID_WIDTH-1:0] id;
  } filter_word_t;

  // Buffer index reached by stepping 'offset' places upward from 'base', wrapping.
  function automatic logic [FILTER_ID_WIDTH-1:0] next_id(input logic [FILTER_ID_WIDTH-1:0] base,
                                                         input int unsigned               offset);
    return FILTER_ID_WIDTH'((32'(base) + offset) % NUM_FILTER);
  endfunction

endpackage

// File: rtl/filter_arbiter_skid.sv
// Two-entry skid FIFO between the capture point and the valid/ready output.
// The head slot is the output register, so out data stays put under backpressure.
module filter_arbiter_skid
  import md_filter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  filter_word_t push_word_i,
  input  logic         ready_i,
  output logic         valid_o,
  output filter_word_t head_o,
  output logic [1:0]   count_o
);

  filter_word_t head_q, head_d;
  filter_word_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         valid_q, valid_d;
  logic         pop_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Push/pop bookkeeping; a push into a full store cannot occur because the arbiter holds credit.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    pop_c   = valid_q & ready_i;
    if (pop_c) begin
      if (count_q == 2'd2) begin
        head_d = tail_q;
        if (push_i) begin
          tail_d = push_word_i;
        end else begin
          count_d = 2'd1;
        end
      end else if (push_i) begin
        head_d = push_word_i;
      end else begin
        count_d = 2'd0;
        valid_d = 1'b0;
      end
    end else if (push_i) begin
      if (count_q == 2'd0) begin
        head_d  = push_word_i;
        count_d = 2'd1;
        valid_d = 1'b1;
      end else if (count_q == 2'd1) begin
        tail_d  = push_word_i;
        count_d = 2'd2;
      end
    end
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/filter_arbiter.sv
// Round-robin drain of the per-filter buffers into a valid/ready stream tagged with source ID.
// Optional stall counter port enabled by defining FILTER_ARBITER_STALL_CNT_EN.
module filter_arbiter
  import md_filter_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_FILTER-1:0]            buffer_empty,
  input  logic [NUM_FILTER*DATA_WIDTH-1:0] buffer_q,
  output logic [NUM_FILTER-1:0]            buffer_rdreq,
  input  logic                             out_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [FILTER_ID_WIDTH-1:0]       out_sel
`ifdef FILTER_ARBITER_STALL_CNT_EN
  ,
  output logic [31:0]                      stall_count
`endif
);

  logic [NUM_FILTER-1:0]      rdreq_q, rdreq_d;
  logic [FILTER_ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [FILTER_ID_WIDTH-1:0] last_grant_q, last_grant_d;

  logic [NUM_FILTER-1:0]      eligible_c;
  logic                       in_flight_c;
  logic                       pop_c;
  logic [2:0]                 occ_c;
  logic                       credit_ok_c;
  logic                       found_c;
  logic [FILTER_ID_WIDTH-1:0] cand_c;
  logic [FILTER_ID_WIDTH-1:0] pick_c;
  logic [1:0]                 skid_count;
  filter_word_t               capture_c;
  filter_word_t               head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdreq_q      <= '0;
      grant_id_q   <= '0;
      last_grant_q <= FILTER_ID_WIDTH'(NUM_FILTER - 1);
    end else begin
      rdreq_q      <= rdreq_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // A buffer read last cycle still shows its stale empty flag, so it sits out one cycle.
  assign eligible_c  = ~buffer_empty & ~rdreq_q;
  assign in_flight_c = |rdreq_q;
  assign pop_c       = out_valid & out_ready;
  assign occ_c       = 3'(skid_count) + 3'(in_flight_c) - 3'(pop_c);
  assign credit_ok_c = occ_c < 3'd2;

  always_comb begin
    rdreq_d      = '0;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    found_c      = 1'b0;
    cand_c       = '0;
    pick_c       = '0;
    for (int unsigned k = 1; k <= NUM_FILTER; k++) begin
      cand_c = next_id(last_grant_q, k);
      if (!found_c && eligible_c[cand_c]) begin
        found_c = 1'b1;
        pick_c  = cand_c;
      end
    end
    if (found_c && credit_ok_c) begin
      rdreq_d[pick_c] = 1'b1;
      grant_id_d      = pick_c;
      last_grant_d    = pick_c;
    end
  end

  // Word returned for the grant issued last cycle.
  always_comb begin
    capture_c.data = '0;
    capture_c.id   = grant_id_q;
    for (int unsigned i = 0; i < NUM_FILTER; i++) begin
      if (grant_id_q == FILTER_ID_WIDTH'(i)) begin
        capture_c.data = buffer_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  filter_arbiter_skid u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_flight_c),
    .push_word_i (capture_c),
    .ready_i     (out_ready),
    .valid_o     (out_valid),
    .head_o      (head),
    .count_o     (skid_count)
  );

  assign buffer_rdreq = rdreq_q;
  assign out_data     = head.data;
  assign out_sel      = head.id;

`ifdef FILTER_ARBITER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where a word waits on downstream.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule
